ipsl_pcie_dma_cpld_tx: RTL and testbench

IPSL_PCIE_DMA_CPLD_TX -- requirements
Module: ipsl_pcie_dma_cpld_tx

---
 rtl/ipsl_pcie_dma_pkg.sv | 45 ++++
 rtl/ipsl_pcie_dma_cpld_align.sv | 31 +++
 rtl/ipsl_pcie_dma_cpld_tx.sv | 128 ++++++++++++
 tb/tb_ipsl_pcie_dma_cpld_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipsl_pcie_dma_pkg.sv
// Shared definitions for the PCIe DMA completion path: CplD header constants,
// TX state encoding and the header/tkeep helpers.
package ipsl_pcie_dma_pkg;

  localparam logic [2:0] CPLD_FMT  = 3'b010;
  localparam logic [4:0] CPLD_TYPE = 5'b01010;

  localparam int unsigned LEN_W   = 10;
  localparam int unsigned BC_W    = 12;
  localparam int unsigned LADDR_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA
  } cpld_state_t;

  // Byte count is 4*N mod 4096, which is {length,2'b00} because length 0 encodes 1024.
  function automatic logic [95:0] cpld_hdr(
    input logic [15:0]        cid,
    input logic [2:0]         tc,
    input logic [2:0]         attr,
    input logic [LEN_W-1:0]   len,
    input logic [15:0]        rid,
    input logic [7:0]         tag,
    input logic [LADDR_W-1:0] laddr
  );
    logic [31:0] dw0, dw1, dw2;
    dw0 = {CPLD_FMT, CPLD_TYPE, 1'b0, tc, 1'b0, attr[2], 2'b00, 1'b0, 1'b0,
           attr[1:0], 2'b00, len};
    dw1 = {cid, 3'b000, 1'b0, len, 2'b00};
    dw2 = {rid, tag, 1'b0, laddr};
    return {dw2, dw1, dw0};
  endfunction

  function automatic logic [3:0] last_keep(input logic [1:0] len_lo);
    case (len_lo)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ipsl_pcie_dma_cpld_align.sv
// Realigns BAR RAM words to a DW offset: the previous word is registered and
// combined with the current RAM output through a 4:1 DW shifter.
module ipsl_pcie_dma_cpld_align (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [1:0]   off_i,
  input  logic [127:0] cur_i,
  output logic [127:0] data_o
);

  logic [127:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else if (en_i) begin
      prev_q <= cur_i;
    end
  end

  always_comb begin
    case (off_i)
      2'd1:    data_o = {cur_i[31:0], prev_q[127:32]};
      2'd2:    data_o = {cur_i[63:0], prev_q[127:64]};
      2'd3:    data_o = {cur_i[95:0], prev_q[127:96]};
      default: data_o = prev_q;
    endcase
  end

endmodule

// File: rtl/ipsl_pcie_dma_cpld_tx.sv
// MRd completion generator: emits one 3DW CplD header beat followed by the
// realigned BAR RAM payload on a 128-bit AXI-Stream, one TLP at a time.
module ipsl_pcie_dma_cpld_tx
  import ipsl_pcie_dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           i_cfg_completer_id,
  input  logic                  i_cpld_req_vld,
  output logic                  o_cpld_req_rdy,
  input  logic [2:0]            i_mrd_tc,
  input  logic [2:0]            i_mrd_attr,
  input  logic [9:0]            i_mrd_length,
  input  logic [15:0]           i_mrd_id,
  input  logic [7:0]            i_mrd_tag,
  input  logic [63:0]           i_mrd_addr,
  output logic                  o_bar_rd_clk_en,
  output logic [ADDR_WIDTH-1:0] o_bar_rd_addr,
  input  logic [127:0]          i_bar_rd_data,
  output logic                  o_axis_slave_tvld,
  input  logic                  i_axis_slave_trdy,
  output logic [127:0]          o_axis_slave_tdata,
  output logic [3:0]            o_axis_slave_tkeep,
  output logic                  o_axis_slave_tlast,
  output logic                  o_busy
);

  cpld_state_t           state_q;
  logic [95:0]           hdr_q;
  logic [1:0]            off_q;
  logic [1:0]            len_lo_q;
  logic [7:0]            beats_rem_q;
  logic [8:0]            rd_rem_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  logic                  accept, advance, rd_more, last_beat;
  logic [9:0]            n_m1;
  logic [10:0]           word_span;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [127:0]          aligned;

  assign o_cpld_req_rdy = (state_q == ST_IDLE) && !rst;
  assign accept         = i_cpld_req_vld && o_cpld_req_rdy;
  assign advance        = (state_q != ST_IDLE) && i_axis_slave_trdy;
  assign rd_more        = advance && (rd_rem_q != '0);
  assign last_beat      = (state_q == ST_DATA) && (beats_rem_q == '0);
  assign start_addr     = i_mrd_addr[ADDR_WIDTH+3:4];

  // N-1 wraps 0 -> 1023, so beats-1 = (N-1)>>2 and words-1 = (off+N-1)>>2.
  assign n_m1      = i_mrd_length - 10'd1;
  assign word_span = {9'b0, i_mrd_addr[3:2]} + {1'b0, n_m1};

  // Word 0 is read at accept, word 1 on the header handshake, then one per data beat.
  assign o_bar_rd_clk_en = accept || rd_more;
  assign o_bar_rd_addr   = accept ? start_addr : rd_addr_q;

  ipsl_pcie_dma_cpld_align u_align (
    .clk    (clk),
    .rst    (rst),
    .en_i   (advance),
    .off_i  (off_q),
    .cur_i  (i_bar_rd_data),
    .data_o (aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hdr_q       <= '0;
      off_q       <= '0;
      len_lo_q    <= '0;
      beats_rem_q <= '0;
      rd_rem_q    <= '0;
      rd_addr_q   <= '0;
    end else begin
      if (rd_more) begin
        rd_rem_q  <= rd_rem_q - 9'd1;
        rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q     <= ST_HDR;
            hdr_q       <= cpld_hdr(i_cfg_completer_id, i_mrd_tc, i_mrd_attr, i_mrd_length,
                                    i_mrd_id, i_mrd_tag, {i_mrd_addr[6:2], 2'b00});
            off_q       <= i_mrd_addr[3:2];
            len_lo_q    <= i_mrd_length[1:0];
            beats_rem_q <= n_m1[9:2];
            rd_rem_q    <= word_span[10:2];
            rd_addr_q   <= start_addr + ADDR_WIDTH'(1);
          end
        end
        ST_HDR: begin
          if (i_axis_slave_trdy) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (i_axis_slave_trdy) begin
            if (beats_rem_q == '0) state_q <= ST_IDLE;
            else                   beats_rem_q <= beats_rem_q - 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_axis_slave_tvld  = (state_q != ST_IDLE);
    o_busy             = (state_q != ST_IDLE);
    o_axis_slave_tlast = last_beat;
    o_axis_slave_tdata = '0;
    o_axis_slave_tkeep = '0;
    case (state_q)
      ST_HDR: begin
        o_axis_slave_tdata = {32'b0, hdr_q};
        o_axis_slave_tkeep = 4'b0111;
      end
      ST_DATA: begin
        o_axis_slave_tdata = aligned;
        o_axis_slave_tkeep = last_beat ? last_keep(len_lo_q) : 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ipsl_pcie_dma_cpld_tx.sv
// Bench for ipsl_pcie_dma_cpld_tx: table-driven and random MRd completions
// compared against a DW-stream model of the BAR RAM contents.
module tb_ipsl_pcie_dma_cpld_tx;

  localparam int unsigned AW    = 9;
  localparam int unsigned WORDS = 512;
  localparam logic [15:0] CID   = 16'hBEEF;

  logic          clk = 1'b0;
  logic          rst, vld, rdy, trdy, tvld, tlast, busy, clk_en;
  logic [2:0]    tc, attr;
  logic [9:0]    len;
  logic [15:0]   id;
  logic [7:0]    tag;
  logic [63:0]   addr;
  logic [AW-1:0] bar_addr;
  logic [127:0]  rd_data, tdata;
  logic [3:0]    tkeep;
  logic [127:0]  mem [WORDS];

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [63:0] addr;
    logic [9:0]  len;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic [15:0] id;
    logic [7:0]  tag;
    int unsigned stall;
    logic [31:0] exp_dw0;
    int unsigned exp_bc;
    int unsigned exp_low;
    int unsigned exp_beats;
    logic [3:0]  exp_last_keep;
  } vec_t;

  always #5 clk = ~clk;

  always @(posedge clk) if (clk_en) rd_data <= mem[bar_addr];

  ipsl_pcie_dma_cpld_tx #(.ADDR_WIDTH(AW)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_cfg_completer_id (CID),
    .i_cpld_req_vld     (vld),
    .o_cpld_req_rdy     (rdy),
    .i_mrd_tc           (tc),
    .i_mrd_attr         (attr),
    .i_mrd_length       (len),
    .i_mrd_id           (id),
    .i_mrd_tag          (tag),
    .i_mrd_addr         (addr),
    .o_bar_rd_clk_en    (clk_en),
    .o_bar_rd_addr      (bar_addr),
    .i_bar_rd_data      (rd_data),
    .o_axis_slave_tvld  (tvld),
    .i_axis_slave_trdy  (trdy),
    .o_axis_slave_tdata (tdata),
    .o_axis_slave_tkeep (tkeep),
    .o_axis_slave_tlast (tlast),
    .o_busy             (busy)
  );

  task automatic check(input bit ok, input string nm, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic bit rnd_rdy(input int unsigned stall);
    return $urandom_range(0, 99) >= stall;
  endfunction

  function automatic int unsigned n_of(input logic [9:0] l);
    return (l == 10'd0) ? 1024 : int'(l);
  endfunction

  // DW i of the requested region, counted from the request address.
  function automatic logic [31:0] src_dw(input logic [63:0] a, input int unsigned i);
    int unsigned abs_dw, w, lane;
    abs_dw = int'((a >> 2) % (4 * WORDS)) + i;
    w      = (abs_dw / 4) % WORDS;
    lane   = abs_dw % 4;
    return mem[w][lane*32 +: 32];
  endfunction

  function automatic vec_t mk(input logic [63:0] a, input logic [9:0] l, input logic [2:0] t,
                              input logic [2:0] at, input logic [15:0] i, input logic [7:0] g,
                              input int unsigned st, input logic [31:0] dw0, input int unsigned bc,
                              input int unsigned low, input int unsigned beats, input logic [3:0] lk);
    vec_t v;
    v.addr = a; v.len = l; v.tc = t; v.attr = at; v.id = i; v.tag = g; v.stall = st;
    v.exp_dw0 = dw0; v.exp_bc = bc; v.exp_low = low; v.exp_beats = beats; v.exp_last_keep = lk;
    return v;
  endfunction

  function automatic vec_t model_vec(input logic [63:0] a, input logic [9:0] l, input logic [2:0] t,
                                     input logic [2:0] at, input logic [15:0] i, input logic [7:0] g,
                                     input int unsigned st);
    int unsigned n;
    logic [31:0] dw0;
    logic [3:0]  lk;
    n   = n_of(l);
    dw0 = 32'h4A000000 | (32'(t) << 20) | (32'(at[2]) << 18) | (32'(at[1:0]) << 12) | 32'(l);
    lk  = (n % 4 == 0) ? 4'hF : 4'((1 << (n % 4)) - 1);
    return mk(a, l, t, at, i, g, st, dw0, (4 * n) % 4096, int'(a % 128) & 32'h7C, (n + 3) / 4, lk);
  endfunction

  task automatic beat_check(input string nm, input logic [63:0] a, input logic [9:0] l, input int unsigned k);
    int unsigned n, rem;
    logic [127:0] exp_d, mask;
    logic [3:0]   exp_k;
    n = n_of(l);
    if (4 * k >= n) begin
      check(1'b0, {nm, "_extra"}, 136'(k), 136'(n));
    end else begin
      rem   = n - 4 * k;
      exp_k = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
      exp_d = '0;
      mask  = '0;
      for (int unsigned j = 0; j < 4; j++) begin
        if (4 * k + j < n) begin
          exp_d[j*32 +: 32] = src_dw(a, 4 * k + j);
          mask[j*32 +: 32]  = '1;
        end
      end
      check(((tdata & mask) == exp_d) && (tkeep == exp_k) && (tlast == (rem <= 4)),
            $sformatf("%s_beat%0d", nm, k),
            {3'b0, tlast, tkeep, tdata & mask}, {3'b0, rem <= 4, exp_k, exp_d});
    end
  endtask

  task automatic run_tlp(input vec_t v, input int unsigned vid);
    int unsigned n, off, words, reads, k, c, rdy_bad;
    bit hdr_done, got_last, prev_stall;
    logic [132:0] cur, prev_beat;
    logic [AW-1:0] base;
    logic [95:0] exp_hdr;
    n = n_of(v.len); off = int'(v.addr[3:2]); words = (off + n + 3) / 4;
    base = AW'((v.addr >> 4) % WORDS);
    exp_hdr = {v.id, v.tag, 8'(v.exp_low), CID, 16'(v.exp_bc), v.exp_dw0};
    reads = 1; k = 0; c = 1; rdy_bad = 0;
    hdr_done = 0; got_last = 0; prev_stall = 0; prev_beat = '0;

    step();
    vld = 1'b1; addr = v.addr; len = v.len; tc = v.tc; attr = v.attr; id = v.id; tag = v.tag;
    trdy = rnd_rdy(v.stall);
    settle();
    check(rdy && clk_en && bar_addr == base, $sformatf("accept[%0d]", vid),
          {rdy, clk_en, bar_addr}, {1'b1, 1'b1, base});
    step();
    vld = 1'b0; trdy = rnd_rdy(v.stall);
    settle();
    check(tvld && tkeep == 4'b0111 && !tlast, $sformatf("hdr_t1[%0d]", vid),
          {tvld, tkeep, tlast}, {1'b1, 4'b0111, 1'b0});

    while (!got_last) begin
      if (c > 3000) begin
        check(1'b0, $sformatf("timeout[%0d]", vid), 136'(k), 136'(v.exp_beats));
        break;
      end
      if (!tvld) begin
        check(1'b0, $sformatf("tvld_drop[%0d]", vid), 136'(tvld), 136'(1));
        break;
      end
      if (rdy) rdy_bad++;
      cur = {tlast, tkeep, tdata};
      if (prev_stall) check(cur == prev_beat, $sformatf("stall_hold[%0d]", vid), 136'(cur), 136'(prev_beat));
      if (!trdy) check(!clk_en, $sformatf("stall_rd[%0d]", vid), 136'(clk_en), 136'(0));
      if (clk_en) reads++;
      if (trdy) begin
        if (!hdr_done) begin
          check(tdata[95:0] == exp_hdr && tkeep == 4'b0111 && !tlast, $sformatf("hdr[%0d]", vid),
                136'(tdata[95:0]), 136'(exp_hdr));
          hdr_done = 1;
        end else begin
          if (v.stall == 0) check(c == k + 2, $sformatf("data_timing[%0d]", vid), 136'(c), 136'(k + 2));
          beat_check($sformatf("data[%0d]", vid), v.addr, v.len, k);
          if (tlast) begin
            got_last = 1;
            check(k + 1 == v.exp_beats && tkeep == v.exp_last_keep, $sformatf("last_beat[%0d]", vid),
                  {tkeep, 32'(k + 1)}, {v.exp_last_keep, 32'(v.exp_beats)});
          end
          k++;
        end
      end
      prev_stall = !trdy;
      prev_beat  = cur;
      step();
      trdy = rnd_rdy(v.stall);
      settle();
      c++;
    end
    check(rdy && !busy && !tvld, $sformatf("idle_after[%0d]", vid), {rdy, busy, tvld}, {1'b1, 1'b0, 1'b0});
    check(rdy_bad == 0, $sformatf("rdy_in_tlp[%0d]", vid), 136'(rdy_bad), 136'(0));
    check(reads <= words, $sformatf("read_count[%0d]", vid), 136'(reads), 136'(words));
  endtask

  vec_t tbl [7];

  initial begin
    for (int unsigned i = 0; i < WORDS; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    rst = 1'b1; vld = 1'b0; trdy = 1'b0;
    addr = '0; len = '0; tc = '0; attr = '0; id = '0; tag = '0;

    tbl[0] = mk(64'h0,    10'd8,   3'd0, 3'd0, 16'h1234, 8'h11, 0,  32'h4A000008, 32,   32'h00, 2,   4'hF);
    tbl[1] = mk(64'h8,    10'd5,   3'd0, 3'd0, 16'hABCD, 8'h22, 0,  32'h4A000005, 20,   32'h08, 2,   4'h1);
    tbl[2] = mk(64'h1FF0, 10'd0,   3'd0, 3'd0, 16'h0101, 8'h33, 0,  32'h4A000000, 0,    32'h70, 256, 4'hF);
    tbl[3] = mk(64'h2C,   10'd16,  3'd0, 3'd0, 16'h0202, 8'h44, 0,  32'h4A000010, 64,   32'h2C, 4,   4'hF);
    tbl[4] = mk(64'h2C,   10'd16,  3'd0, 3'd0, 16'h0202, 8'h44, 50, 32'h4A000010, 64,   32'h2C, 4,   4'hF);
    tbl[5] = mk(64'h104,  10'd3,   3'd5, 3'd7, 16'h0303, 8'h55, 0,  32'h4A543003, 12,   32'h04, 1,   4'h7);
    tbl[6] = mk(64'h1234_5678_9ABC_DEF4, 10'd1023, 3'd2, 3'd1, 16'hC0DE, 8'hA5, 30,
                32'h4A2013FF, 4092, 32'h74, 256, 4'h7);

    repeat (3) step();
    check(!rdy && !tvld && !busy && !clk_en && !tlast && tdata == '0 && tkeep == '0 && bar_addr == '0,
          "reset_state", {rdy, tvld, busy, clk_en, tlast, tkeep, bar_addr}, 136'(0));
    step();
    rst = 1'b0;

    for (int unsigned i = 0; i < 7; i++) run_tlp(tbl[i], i);

    // Reset during data beat 2 of a 32-DW completion.
    step();
    vld = 1'b1; addr = 64'h40; len = 10'd32; tc = 3'd0; attr = 3'd0; id = 16'h5555; tag = 8'h66;
    trdy = 1'b1;
    settle();
    step(); vld = 1'b0; settle();
    step(); settle();
    step(); settle();
    step(); settle();
    beat_check("pre_rst", 64'h40, 10'd32, 2);
    rst = 1'b1;
    settle();
    check(!rdy, "rdy_in_rst", 136'(rdy), 136'(0));
    step();
    rst = 1'b0;
    settle();
    check(!tvld && !tlast && tkeep == '0 && tdata == '0 && !busy && !clk_en && bar_addr == '0,
          "rst_mid_tlp", {tvld, tlast, tkeep, busy, clk_en, bar_addr, tdata[63:0]}, 136'(0));
    run_tlp(model_vec(64'h40, 10'd32, 3'd1, 3'd2, 16'h5555, 8'h66, 0), 50);

    // Back-to-back requests with vld held: len=1 then len=4.
    step();
    vld = 1'b1; addr = 64'h34; len = 10'd1; tc = 3'd0; attr = 3'd0; id = 16'h0A0A; tag = 8'h01;
    trdy = 1'b1;
    settle();
    check(rdy, "b2b_acceptA", 136'(rdy), 136'(1));
    step();
    addr = 64'h88; len = 10'd4; id = 16'h0B0B; tag = 8'h02;
    settle();
    check(!rdy && tvld && tkeep == 4'b0111 && tdata[31:0] == 32'h4A000001, "b2b_hdrA",
          {rdy, tvld, tkeep, tdata[31:0]}, {1'b0, 1'b1, 4'b0111, 32'h4A000001});
    step(); settle();
    check(!rdy, "b2b_rdy_low", 136'(rdy), 136'(0));
    beat_check("b2b_dataA", 64'h34, 10'd1, 0);
    step(); settle();
    check(rdy && clk_en && bar_addr == 9'h008 && !tvld, "b2b_acceptB",
          {rdy, clk_en, tvld, bar_addr}, {1'b1, 1'b1, 1'b0, 9'h008});
    step();
    vld = 1'b0;
    settle();
    check(tvld && tkeep == 4'b0111 && tdata[95:0] == {16'h0B0B, 8'h02, 8'h08, CID, 16'd16, 32'h4A000004},
          "b2b_hdrB", 136'(tdata[95:0]), 136'({16'h0B0B, 8'h02, 8'h08, CID, 16'd16, 32'h4A000004}));
    step(); settle();
    beat_check("b2b_dataB", 64'h88, 10'd4, 0);
    step(); settle();
    check(!tvld && rdy, "b2b_idle", {tvld, rdy}, {1'b0, 1'b1});

    for (int unsigned i = 0; i < 8; i++) begin
      logic [9:0] rl;
      rl = (i % 3 == 0) ? 10'($urandom) : 10'($urandom_range(1, 24));
      run_tlp(model_vec({$urandom, $urandom}, rl, 3'($urandom), 3'($urandom), 16'($urandom),
                        8'($urandom), (i % 2 == 0) ? 0 : $urandom_range(20, 70)), 100 + i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
